// File: rtl/ifetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width, the
// bubble instruction and the fetch FSM state encoding.
package ifetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/ifetch_stage_ifid_reg.sv
// IF/ID pipeline register: clear, flush (bubble), load or hold.
// Flush/bubble leaves the PC fields alone and only kills valid and the word.
module ifid_reg
  import ifetch_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic [XLEN-1:0] inst_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
      pc4_o   <= '0;
      inst_o  <= NOP;
    end else if (clr_i) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
      pc4_o   <= '0;
      inst_o  <= NOP;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      inst_o  <= NOP;
    end else if (load_i) begin
      valid_o <= 1'b1;
      pc_o    <= pc_i;
      pc4_o   <= pc_i + XLEN'(4);
      inst_o  <= inst_i;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: req/ack fetch FSM, one-entry skid buffer for ID
// stalls, drain of wrong-path requests after a flush, and PC stall control.
module ifetch_stage
  import ifetch_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_stall_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_data_i,
  input  logic            stall_id_i,
  input  logic            flush_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc4_o,
  output logic [XLEN-1:0] ifid_inst_o,
  output logic [1:0]      state_o
);

  // Memory handshake: imem_req_o stays high until imem_ack_i, and
  // imem_addr_o is stable for the whole time imem_req_o is high; ack may
  // arrive in the same cycle req rises, and data is taken only with ack.

  state_e          state_q;
  logic [XLEN-1:0] addr_q;
  logic            skid_valid_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [XLEN-1:0] skid_inst_q;

  logic            slot_free;
  logic            ifid_load;
  logic            ifid_kill;
  logic [XLEN-1:0] ld_pc;
  logic [XLEN-1:0] ld_inst;

  assign slot_free   = !ifid_valid_o || !stall_id_i;
  assign imem_addr_o = (state_q == DRAIN) ? addr_q : pc_i;
  assign state_o     = state_q;

  always_comb begin
    imem_req_o = 1'b0;
    pc_stall_o = 1'b0;
    ifid_load  = 1'b0;
    ld_pc      = pc_i;
    ld_inst    = imem_data_i;
    if (start_i) begin
      case (state_q)
        REQ: begin
          imem_req_o = 1'b1;
          pc_stall_o = !imem_ack_i && !flush_i;
          ifid_load  = imem_ack_i && slot_free && !flush_i;
        end
        HOLD: begin
          pc_stall_o = !flush_i;
          if (skid_valid_q && !stall_id_i && !flush_i) begin
            ifid_load = 1'b1;
            ld_pc     = skid_pc_q;
            ld_inst   = skid_inst_q;
          end
        end
        DRAIN: begin
          imem_req_o = 1'b1;
          pc_stall_o = !flush_i;
        end
        default: ;
      endcase
    end
  end

  // An unstalled ID consumes the current entry, so anything not reloaded
  // and not held becomes a bubble.
  assign ifid_kill = flush_i || (!ifid_load && !(stall_id_i && ifid_valid_o));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP;
    end else if (!start_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          addr_q <= pc_i;
          if (flush_i) begin
            state_q <= imem_ack_i ? REQ : DRAIN;
          end else if (imem_ack_i && !slot_free) begin
            skid_valid_q <= 1'b1;
            skid_pc_q    <= pc_i;
            skid_inst_q  <= imem_data_i;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (flush_i || !stall_id_i) begin
            skid_valid_q <= 1'b0;
            state_q      <= REQ;
          end
        end
        DRAIN: begin
          if (imem_ack_i && !flush_i) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (!start_i),
    .load_i  (ifid_load),
    .flush_i (ifid_kill),
    .pc_i    (ld_pc),
    .inst_i  (ld_inst),
    .valid_o (ifid_valid_o),
    .pc_o    (ifid_pc_o),
    .pc4_o   (ifid_pc4_o),
    .inst_o  (ifid_inst_o)
  );

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed-vector bench for ifetch_stage: zero-wait and wait-state fetch,
// skid on ID stall, flush drain, flush in HOLD, async reset and PC+4 wrap.
module tb_ifetch_stage;
  import ifetch_stage_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic [XLEN-1:0] pc_i;
  logic            pc_stall_o;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [XLEN-1:0] imem_data_i;
  logic            stall_id_i;
  logic            flush_i;
  logic            ifid_valid_o;
  logic [XLEN-1:0] ifid_pc_o;
  logic [XLEN-1:0] ifid_pc4_o;
  logic [XLEN-1:0] ifid_inst_o;
  logic [1:0]      state_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ifetch_stage dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .pc_stall_o   (pc_stall_o),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .stall_id_i   (stall_id_i),
    .flush_i      (flush_i),
    .ifid_valid_o (ifid_valid_o),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_pc4_o   (ifid_pc4_o),
    .ifid_inst_o  (ifid_inst_o),
    .state_o      (state_o)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [XLEN-1:0] pc, input logic ack,
                       input logic [XLEN-1:0] data, input logic stall_id,
                       input logic flush);
    pc_i        = pc;
    imem_ack_i  = ack;
    imem_data_i = data;
    stall_id_i  = stall_id;
    flush_i     = flush;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    n_vec++; if (ifid_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b, expected 0", ifid_valid_o); end
    n_vec++; if (ifid_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h, expected 0", ifid_pc_o); end
    n_vec++; if (ifid_pc4_o !== 32'h0) begin n_err++; $display("FAIL reset_pc4: got %h, expected 0", ifid_pc4_o); end
    n_vec++; if (ifid_inst_o !== NOP) begin n_err++; $display("FAIL reset_inst: got %h, expected %h", ifid_inst_o, NOP); end
    n_vec++; if (imem_req_o !== 1'b0 || pc_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_req_stall: got req=%0b stall=%0b, expected 0 0", imem_req_o, pc_stall_o); end
    step();
    rst_i = 1'b1;
    step();
    start_i = 1'b1;
    step(); // IDLE -> REQ
    n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL start_state: got %0d, expected 1", state_o); end
  endtask

  task automatic test_zero_wait();
    logic [XLEN-1:0] pc;
    for (int i = 0; i < 3; i++) begin
      pc = 32'(4 * i);
      drive(pc, 1'b1, 32'h0010_0093 + 32'(i << 20), 1'b0, 1'b0);
      n_vec++; if (pc_stall_o !== 1'b0 || imem_req_o !== 1'b1) begin n_err++; $display("FAIL zw_stall_req[%0d]: got stall=%0b req=%0b, expected 0 1", i, pc_stall_o, imem_req_o); end
      step();
      n_vec++; if (ifid_valid_o !== 1'b1 || ifid_pc_o !== pc) begin n_err++; $display("FAIL zw_pc[%0d]: got v=%0b pc=%h, expected 1 %h", i, ifid_valid_o, ifid_pc_o, pc); end
      n_vec++; if (ifid_pc4_o !== pc + 32'd4) begin n_err++; $display("FAIL zw_pc4[%0d]: got %h, expected %h", i, ifid_pc4_o, pc + 32'd4); end
      n_vec++; if (ifid_inst_o !== 32'h0010_0093 + 32'(i << 20)) begin n_err++; $display("FAIL zw_inst[%0d]: got %h, expected %h", i, ifid_inst_o, 32'h0010_0093 + 32'(i << 20)); end
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      drive(32'h40, 1'b0, 32'hxxxx_xxxx, 1'b0, 1'b0);
      n_vec++; if (pc_stall_o !== 1'b1) begin n_err++; $display("FAIL ws_stall[%0d]: got %0b, expected 1", i, pc_stall_o); end
      n_vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin n_err++; $display("FAIL ws_addr[%0d]: got req=%0b addr=%h, expected 1 00000040", i, imem_req_o, imem_addr_o); end
      step();
    end
    drive(32'h40, 1'b1, 32'h0400_0513, 1'b0, 1'b0);
    n_vec++; if (pc_stall_o !== 1'b0) begin n_err++; $display("FAIL ws_ack_stall: got %0b, expected 0", pc_stall_o); end
    step();
    n_vec++; if (ifid_pc_o !== 32'h40 || ifid_inst_o !== 32'h0400_0513) begin n_err++; $display("FAIL ws_ifid: got pc=%h inst=%h, expected 00000040 04000513", ifid_pc_o, ifid_inst_o); end
  endtask

  task automatic test_skid();
    drive(32'h0C, 1'b1, 32'h00C0_0C0C, 1'b0, 1'b0);
    step();
    drive(32'h10, 1'b1, 32'h0100_1010, 1'b1, 1'b0);
    n_vec++; if (pc_stall_o !== 1'b0) begin n_err++; $display("FAIL skid_ack_stall: got %0b, expected 0", pc_stall_o); end
    step();
    drive(32'h14, 1'b0, 32'h0, 1'b1, 1'b0);
    n_vec++; if (state_o !== 2'd2 || imem_req_o !== 1'b0 || pc_stall_o !== 1'b1) begin n_err++; $display("FAIL skid_hold: got st=%0d req=%0b stall=%0b, expected 2 0 1", state_o, imem_req_o, pc_stall_o); end
    n_vec++; if (ifid_pc_o !== 32'h0C || ifid_inst_o !== 32'h00C0_0C0C || ifid_valid_o !== 1'b1) begin n_err++; $display("FAIL skid_retain: got v=%0b pc=%h inst=%h, expected 1 0000000c 00c00c0c", ifid_valid_o, ifid_pc_o, ifid_inst_o); end
    step();
    drive(32'h14, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    n_vec++; if (ifid_pc_o !== 32'h10 || ifid_pc4_o !== 32'h14 || ifid_inst_o !== 32'h0100_1010) begin n_err++; $display("FAIL skid_release: got pc=%h pc4=%h inst=%h, expected 00000010 00000014 01001010", ifid_pc_o, ifid_pc4_o, ifid_inst_o); end
    n_vec++; if (state_o !== 2'd1 || imem_addr_o !== 32'h14) begin n_err++; $display("FAIL skid_next_req: got st=%0d addr=%h, expected 1 00000014", state_o, imem_addr_o); end
  endtask

  task automatic test_flush_drain();
    drive(32'h20, 1'b0, 32'h0, 1'b0, 1'b1);
    n_vec++; if (pc_stall_o !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %0b, expected 0", pc_stall_o); end
    step();
    drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++; if (state_o !== 2'd3 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h20) begin n_err++; $display("FAIL fl_drain: got st=%0d req=%0b addr=%h, expected 3 1 00000020", state_o, imem_req_o, imem_addr_o); end
    n_vec++; if (pc_stall_o !== 1'b1 || ifid_valid_o !== 1'b0) begin n_err++; $display("FAIL fl_drain_stall: got stall=%0b v=%0b, expected 1 0", pc_stall_o, ifid_valid_o); end
    step();
    drive(32'h100, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    n_vec++; if (imem_addr_o !== 32'h20 || pc_stall_o !== 1'b1) begin n_err++; $display("FAIL fl_drain_ack: got addr=%h stall=%0b, expected 00000020 1", imem_addr_o, pc_stall_o); end
    step();
    n_vec++; if (ifid_valid_o !== 1'b0 || ifid_inst_o !== NOP) begin n_err++; $display("FAIL fl_discard: got v=%0b inst=%h, expected 0 %h", ifid_valid_o, ifid_inst_o, NOP); end
    drive(32'h100, 1'b1, 32'h1001_0001, 1'b0, 1'b0);
    n_vec++; if (imem_addr_o !== 32'h100 || pc_stall_o !== 1'b0) begin n_err++; $display("FAIL fl_refetch: got addr=%h stall=%0b, expected 00000100 0", imem_addr_o, pc_stall_o); end
    step();
    n_vec++; if (ifid_pc_o !== 32'h100 || ifid_inst_o !== 32'h1001_0001) begin n_err++; $display("FAIL fl_target: got pc=%h inst=%h, expected 00000100 10010001", ifid_pc_o, ifid_inst_o); end
  endtask

  task automatic test_flush_stall_hold();
    drive(32'h104, 1'b1, 32'h1041_0401, 1'b1, 1'b0);
    step();
    drive(32'h108, 1'b0, 32'h0, 1'b1, 1'b1);
    n_vec++; if (state_o !== 2'd2 || pc_stall_o !== 1'b0) begin n_err++; $display("FAIL fsh_hold: got st=%0d stall=%0b, expected 2 0", state_o, pc_stall_o); end
    step();
    drive(32'h108, 1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++; if (ifid_valid_o !== 1'b0 || ifid_inst_o !== NOP || state_o !== 2'd1) begin n_err++; $display("FAIL fsh_squash: got v=%0b inst=%h st=%0d, expected 0 %h 1", ifid_valid_o, ifid_inst_o, state_o, NOP); end
    step();
    n_vec++; if (ifid_valid_o !== 1'b0 || ifid_inst_o === 32'h1041_0401) begin n_err++; $display("FAIL fsh_skid_dropped: got v=%0b inst=%h, expected 0 %h", ifid_valid_o, ifid_inst_o, NOP); end
  endtask

  task automatic test_wrap_async_reset();
    drive(32'hFFFF_FFFC, 1'b1, 32'hFFC0_FFC0, 1'b0, 1'b0);
    step();
    n_vec++; if (ifid_pc_o !== 32'hFFFF_FFFC || ifid_pc4_o !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got pc=%h pc4=%h, expected fffffffc 00000000", ifid_pc_o, ifid_pc4_o); end
    drive(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++; if (imem_req_o !== 1'b1 || pc_stall_o !== 1'b1) begin n_err++; $display("FAIL ar_pre: got req=%0b stall=%0b, expected 1 1", imem_req_o, pc_stall_o); end
    #1 rst_i = 1'b0;
    #1;
    n_vec++; if (imem_req_o !== 1'b0 || pc_stall_o !== 1'b0 || state_o !== 2'd0) begin n_err++; $display("FAIL ar_ctrl: got req=%0b stall=%0b st=%0d, expected 0 0 0", imem_req_o, pc_stall_o, state_o); end
    n_vec++; if (ifid_valid_o !== 1'b0 || ifid_pc_o !== 32'h0 || ifid_pc4_o !== 32'h0 || ifid_inst_o !== NOP) begin n_err++; $display("FAIL ar_ifid: got v=%0b pc=%h pc4=%h inst=%h, expected 0 0 0 %h", ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_inst_o, NOP); end
    step();
    rst_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_skid();
    test_flush_drain();
    test_flush_stall_hold();
    test_wrap_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, expected completion before 100000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the pipelined CPU, directly downstream of the PC register. It takes the current PC, runs a req/ack handshake with the instruction memory, and fills the IF/ID pipeline register. It drives the PC register's stall input whenever a fetch cannot retire. It also absorbs ID-stage stalls through a one-entry skid buffer and squashes wrong-path fetches on a branch flush.

## Interface
- XLEN, 32: address/instruction width
- NOP, 32'h0000_0000: instruction word injected on flush/empty

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  CPU run enable; low acts as a synchronous clear
- pc_i  in  XLEN  current PC (PC register output)
- pc_stall_o  out  1  to PC register stall input; 1 = hold PC
- imem_req_o  out  1  fetch request, held until ack
- imem_addr_o  out  XLEN  fetch address, stable while imem_req_o=1
- imem_ack_i  in  1  data valid; may be asserted in the same cycle as req
- imem_data_i  in  XLEN  instruction word, sampled when imem_ack_i=1
- stall_id_i  in  1  ID stage cannot accept; hold IF/ID
- flush_i  in  1  branch/jump taken in ID; squash IF
- ifid_valid_o  out  1  IF/ID holds a live instruction
- ifid_pc_o  out  XLEN  PC of the IF/ID instruction
- ifid_pc4_o  out  XLEN  ifid_pc_o + 4, mod 2^XLEN
- ifid_inst_o  out  XLEN  instruction word

## Operation
- Reset (rst_i=0, async) and start_i=0 (sync) both force:
  - state IDLE
  - ifid_valid_o=0, ifid_pc_o=0, ifid_pc4_o=0, ifid_inst_o=NOP
  - imem_req_o=0, pc_stall_o=0
  - skid buffer empty
- start_i=0 abandons any outstanding request. The memory tolerates req dropping.
- slot_free = !ifid_valid_o || !stall_id_i.
- States:
  - **IDLE**:
    - req=0.
    - If start_i=1, go to REQ next cycle.
  - **REQ**:
    - req=1, imem_addr_o=pc_i. The address register addr_q also loads pc_i every cycle.
    - Ack with slot_free: IF/ID loads {pc_i, pc_i+4, imem_data_i}, valid=1; pc_stall_o=0; stay in REQ.
    - Ack without slot_free: skid loads {pc_i, imem_data_i}; pc_stall_o=0; go to HOLD.
    - No ack: pc_stall_o=1.
  - **HOLD**:
    - req=0, pc_stall_o=1.
    - When stall_id_i=0: IF/ID loads from skid, skid empties, go to REQ.
  - **DRAIN**:
    - req=1, imem_addr_o=addr_q, pc_stall_o=1.
    - On ack: discard the data, go to REQ.
- When stall_id_i=1 and ifid_valid_o=1, IF/ID holds all fields unchanged.
- flush_i=1 overrides everything else in the same cycle:
  - pc_stall_o=0, so the PC takes the redirect target.
  - Next edge: ifid_valid_o=0, ifid_inst_o=NOP, skid emptied.
  - In REQ without ack: go to DRAIN (the request already issued to addr_q must complete).
  - In REQ with ack: data discarded; stay in REQ.
  - In HOLD: go to REQ.
  - In DRAIN: stay in DRAIN.
- If flush_i and stall_id_i are both 1, flush wins.
- ifid_pc4_o wraps modulo 2^XLEN (0xFFFF_FFFC gives 0x0000_0000).

## Timing
- Zero-wait memory (ack in the req cycle): one instruction per clock. IF/ID updates at the edge ending the ack cycle.
- N-wait memory: pc_stall_o=1 for N cycles, then 0 in the ack cycle.
- pc_stall_o and imem_req_o are combinational from state plus inputs. All ifid_* outputs are registered.
- imem_addr_o is guaranteed stable for as long as imem_req_o=1. In REQ this holds because the PC is held. In DRAIN it holds because addr_q is used.
- Skid depth is 1. HOLD never issues a request, so the skid can never overflow.

## Structure
- Shared package holds:
  - XLEN
  - NOP
  - state encoding: IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DRAIN=2'd3
- Sub-module ifid_reg: the IF/ID register with load/hold/flush inputs, reused by the hazard-unit tests.
- Top level contains the FSM, addr_q, the skid buffer and the stall logic.

## Test plan
- Reset, then start_i=1 with pc_i stepping 0,4,8 and zero-wait ack → ifid_inst_o follows the memory each cycle, ifid_pc4_o = 4,8,12, pc_stall_o never 1.
- Ack delayed 3 cycles at pc_i=0x40 → pc_stall_o=1 for 3 cycles, imem_addr_o=0x40 held throughout, ifid_pc_o=0x40 after ack.
- stall_id_i=1 for 2 cycles while ack arrives for 0x10 → HOLD, IF/ID retains 0x0C; after release ifid_pc_o=0x10 with the correct instruction.
- flush_i in REQ with no ack at 0x20, pc_i then 0x100 → DRAIN keeps addr 0x20 until ack; data discarded; next fetch at 0x100; ifid_valid_o=0 meanwhile.
- flush_i and stall_id_i both 1 in HOLD → skid dropped, ifid_inst_o=NOP, pc_stall_o=0 that cycle.
- rst_i pulled low mid-REQ (asynchronously, between clock edges) → all outputs reach reset values immediately; pc_i=0xFFFF_FFFC gives ifid_pc4_o=0.
